// File: rtl/seq_datapath.sv
// Self-sequencing single-bus datapath slice.
// A register file, Y operand register, Z result register and ALU share one internal bus.
// One start request runs the sequence Ra <- Rb op (Rc | imm) as IDLE -> TY -> TZ -> TWB.
//
// Ports:
//   clk, clear (async active-low)   clock and reset
//   start, op, ra, rb, rc           operation request; fields are latched in IDLE
//   imm_en, imm                     immediate second operand
//   ld_en, ld_addr, ld_data         direct register write, honoured only in IDLE
//   rd_addr, rd_data                combinational debug read port
//   busy, done                      handshake: busy for 3 cycles, then a 1-cycle done pulse
//   result, z_flag, n_flag, c_flag  last written-back value and its flags
module seq_datapath #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 16,
  parameter bit          ZERO_R0  = 1'b1,
  localparam int unsigned REG_AW  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [REG_AW-1:0] ra,
  input  logic [REG_AW-1:0] rb,
  input  logic [REG_AW-1:0] rc,
  input  logic              imm_en,
  input  logic [DATA_W-1:0] imm,
  input  logic              ld_en,
  input  logic [REG_AW-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [REG_AW-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              z_flag,
  output logic              n_flag,
  output logic              c_flag
);

  localparam int unsigned SH_W = $clog2(DATA_W);

  typedef enum logic [1:0] {StIdle, StTy, StTz, StTwb} state_e;

  state_e              state_q, state_d;
  logic [2:0]          op_q;
  logic [REG_AW-1:0]   ra_q, rb_q, rc_q;
  logic                imm_en_q;
  logic [DATA_W-1:0]   imm_q;
  logic [DATA_W-1:0]   y_q, z_q;
  logic                zc_q;  // carry produced alongside Z, published with the flags at TWB
  logic [DATA_W-1:0]   regs_q  [NUM_REGS];
  logic [DATA_W-1:0]   rf_view [NUM_REGS];
  logic                busy_q, done_q, z_flag_q, n_flag_q, c_flag_q;
  logic [DATA_W-1:0]   result_q;
  logic [DATA_W-1:0]   bus;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c;
  logic [SH_W-1:0]     shamt;

  // Read view of the register file; R0 is forced to zero when hard-wired.
  always_comb begin
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      rf_view[i] = (ZERO_R0 && i == 0) ? '0 : regs_q[i];
    end
  end

  assign rd_data = rf_view[rd_addr];

  // Single shared bus, driven by whichever source the current step needs.
  always_comb begin
    bus = '0;
    unique case (state_q)
      StIdle: bus = '0;
      StTy:   bus = rf_view[rb_q];
      StTz:   bus = imm_en_q ? imm_q : rf_view[rc_q];
      StTwb:  bus = z_q;
    endcase
  end

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    shamt   = bus[SH_W-1:0];
    unique case (op_q)
      3'b000: {alu_c, alu_res} = {1'b0, y_q} + {1'b0, bus};
      3'b001: begin
        alu_res = y_q - bus;
        alu_c   = (y_q < bus);
      end
      3'b010: alu_res = y_q & bus;
      3'b011: alu_res = y_q | bus;
      3'b100: alu_res = y_q << shamt;
      3'b101: alu_res = y_q >> shamt;
      // Rotate: shift the doubled word so bits leaving the bottom re-enter at the top.
      3'b110: alu_res = DATA_W'({y_q, y_q} >> shamt);
      3'b111: alu_res = ~y_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StTy;
      StTy:   state_d = StTz;
      StTz:   state_d = StTwb;
      StTwb:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q  <= StIdle;
      op_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rc_q     <= '0;
      imm_en_q <= 1'b0;
      imm_q    <= '0;
      y_q      <= '0;
      z_q      <= '0;
      zc_q     <= 1'b0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      z_flag_q <= 1'b0;
      n_flag_q <= 1'b0;
      c_flag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Load lands before TY, so a same-cycle start reads the loaded value.
          if (ld_en && !(ZERO_R0 && ld_addr == '0)) begin
            regs_q[ld_addr] <= ld_data;
          end
          if (start) begin
            op_q     <= op;
            ra_q     <= ra;
            rb_q     <= rb;
            rc_q     <= rc;
            imm_en_q <= imm_en;
            imm_q    <= imm;
            busy_q   <= 1'b1;
          end
        end
        StTy: y_q <= bus;
        StTz: begin
          z_q  <= alu_res;
          zc_q <= alu_c;
        end
        StTwb: begin
          if (!(ZERO_R0 && ra_q == '0)) begin
            regs_q[ra_q] <= bus;
          end
          result_q <= bus;
          z_flag_q <= (bus == '0);
          n_flag_q <= bus[DATA_W-1];
          c_flag_q <= zc_q;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign z_flag = z_flag_q;
  assign n_flag = n_flag_q;
  assign c_flag = c_flag_q;

endmodule

// File: tb/tb_seq_datapath.sv
// Bench for seq_datapath: a transaction-level model checked every cycle on a 32-bit/16-reg
// instance, directed literal cases, random traffic, and a small 8-bit/4-reg instance.
module tb_seq_datapath;

  localparam int DW = 32;
  localparam int NR = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          clear = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    op = '0;
  logic [AW-1:0] ra = '0, rb = '0, rc = '0, ld_addr = '0, rd_addr = '0;
  logic          imm_en = 1'b0, ld_en = 1'b0;
  logic [DW-1:0] imm = '0, ld_data = '0;
  logic [DW-1:0] rd_data, result;
  logic          busy, done, z_flag, n_flag, c_flag;

  // Small instance
  logic       s_start = 1'b0, s_imm_en = 1'b0, s_ld_en = 1'b0;
  logic [2:0] s_op = '0;
  logic [1:0] s_ra = '0, s_rb = '0, s_rc = '0, s_ld_addr = '0, s_rd_addr = '0;
  logic [7:0] s_imm = '0, s_ld_data = '0;
  logic [7:0] s_rd_data, s_result;
  logic       s_busy, s_done, s_z, s_n, s_c;

  always #5 clk = ~clk;

  seq_datapath #(.DATA_W(DW), .NUM_REGS(NR), .ZERO_R0(1'b1)) dut (
    .clk(clk), .clear(clear), .start(start), .op(op), .ra(ra), .rb(rb), .rc(rc),
    .imm_en(imm_en), .imm(imm), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done), .result(result),
    .z_flag(z_flag), .n_flag(n_flag), .c_flag(c_flag)
  );

  seq_datapath #(.DATA_W(8), .NUM_REGS(4), .ZERO_R0(1'b1)) dut_small (
    .clk(clk), .clear(clear), .start(s_start), .op(s_op), .ra(s_ra), .rb(s_rb), .rc(s_rc),
    .imm_en(s_imm_en), .imm(s_imm), .ld_en(s_ld_en), .ld_addr(s_ld_addr),
    .ld_data(s_ld_data), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .busy(s_busy),
    .done(s_done), .result(s_result), .z_flag(s_z), .n_flag(s_n), .c_flag(s_c)
  );

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- Reference model ----------------
  logic [DW-1:0] m_regs [NR];
  logic          m_busy, m_done, m_z, m_n, m_c;
  logic [DW-1:0] m_res;
  int            m_cnt;
  logic [AW-1:0] p_ra;
  logic [DW-1:0] p_val;
  logic          p_c;

  function automatic logic [DW:0] model_alu(input logic [2:0] o, input logic [DW-1:0] y,
                                            input logic [DW-1:0] b);
    longint unsigned s;
    int              sh;
    logic [DW-1:0]   r;
    logic            c;
    sh = int'(b % DW);
    r  = '0;
    c  = 1'b0;
    case (o)
      3'd0: begin
        s = longint'(y) + longint'(b);
        r = s[DW-1:0];
        c = (s >= 64'h1_0000_0000);
      end
      3'd1: begin
        r = y - b;
        c = (y < b);
      end
      3'd2: r = y & b;
      3'd3: r = y | b;
      3'd4: r = y << sh;
      3'd5: r = y >> sh;
      3'd6: begin
        r = y;
        for (int k = 0; k < sh; k++) r = {r[0], r[DW-1:1]};
      end
      default: r = ~y;
    endcase
    return {c, r};
  endfunction

  // Transaction-level model: accept in idle, count down three steps, then write back.
  always @(posedge clk or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < NR; i++) m_regs[i] = '0;
      m_busy = 0; m_done = 0; m_z = 0; m_n = 0; m_c = 0; m_res = '0; m_cnt = 0;
    end else begin
      m_done = 0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          if (p_ra != 0) m_regs[p_ra] = p_val;
          m_res  = p_val;
          m_z    = (p_val == 0);
          m_n    = p_val[DW-1];
          m_c    = p_c;
          m_busy = 0;
          m_done = 1;
        end
      end else begin
        if (ld_en && ld_addr != 0) m_regs[ld_addr] = ld_data;
        if (start) begin
          {p_c, p_val} = model_alu(op, m_regs[rb], imm_en ? imm : m_regs[rc]);
          p_ra   = ra;
          m_cnt  = 3;
          m_busy = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (clear && chk_on) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("result", result, m_res);
      check("z_flag", z_flag, m_z);
      check("n_flag", n_flag, m_n);
      check("c_flag", c_flag, m_c);
      check("rd_data", rd_data, m_regs[rd_addr]);
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk); #1;
    ld_en = 1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 0;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [AW-1:0] a, input logic [AW-1:0] b,
                        input logic [AW-1:0] c, input logic ie, input logic [DW-1:0] im,
                        input bit disturb, output int lat, output int busy_cyc);
    @(posedge clk); #1;
    op = o; ra = a; rb = b; rc = c; imm_en = ie; imm = im; start = 1;
    @(posedge clk); #1;
    start = 0;
    lat = 0;
    busy_cyc = busy ? 1 : 0;
    for (int k = 1; k <= 10; k++) begin
      if (disturb && k == 1) begin
        start = 1; op = 3'd7; ra = 4'd1; ld_en = 1; ld_addr = 4'd1; ld_data = 32'd100;
      end
      @(posedge clk); #1;
      if (disturb && k == 1) begin
        start = 0; ld_en = 0;
      end
      if (busy) busy_cyc++;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic rd_check(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    rd_addr = a;
    #1;
    check(name, rd_data, exp);
  endtask

  int lat, bc, extra;

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    rd_check("reset_r1", 4'd1, 0);
    clear = 1;
    chk_on = 1;

    // ADD
    load(4'd1, 32'd5);
    load(4'd2, 32'd7);
    run_op(3'd0, 4'd3, 4'd1, 4'd2, 0, 0, 0, lat, bc);
    check("add_latency", lat, 3);
    check("add_busy_cycles", bc, 3);
    check("add_result", result, 32'd12);
    check("add_z", z_flag, 0);
    check("add_c", c_flag, 0);
    rd_check("add_r3", 4'd3, 32'd12);

    // SUB
    load(4'd1, 32'd3);
    load(4'd2, 32'd5);
    run_op(3'd1, 4'd4, 4'd1, 4'd2, 0, 0, 0, lat, bc);
    check("sub_result", result, 32'hFFFF_FFFE);
    check("sub_n", n_flag, 1);
    check("sub_c", c_flag, 1);
    rd_check("sub_r4", 4'd4, 32'hFFFF_FFFE);
    run_op(3'd1, 4'd5, 4'd2, 4'd2, 0, 0, 0, lat, bc);
    check("sub_self_z", z_flag, 1);
    check("sub_self_c", c_flag, 0);

    // Shifts and rotate with immediates
    load(4'd1, 32'h8000_0001);
    run_op(3'd4, 4'd6, 4'd1, 4'd0, 1, 32'd1, 0, lat, bc);
    check("shl_result", result, 32'h0000_0002);
    run_op(3'd6, 4'd6, 4'd1, 4'd0, 1, 32'd33, 0, lat, bc);
    check("ror_result", result, 32'hC000_0000);
    run_op(3'd5, 4'd6, 4'd1, 4'd0, 1, 32'd31, 0, lat, bc);
    check("shr_result", result, 32'h0000_0001);

    // Write to R0 discarded, result and done still produced
    load(4'd1, 32'd9);
    run_op(3'd0, 4'd0, 4'd1, 4'd0, 1, 32'd1, 0, lat, bc);
    check("r0_latency", lat, 3);
    check("r0_result", result, 32'd10);
    rd_check("r0_read", 4'd0, 0);

    // start and ld_en while busy are ignored
    run_op(3'd0, 4'd7, 4'd1, 4'd1, 0, 0, 1, lat, bc);
    check("ign_busy_cycles", bc, 3);
    check("ign_result", result, 32'd18);
    rd_check("ign_r1", 4'd1, 32'd9);
    extra = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    check("ign_no_queued", extra, 0);

    // start held through done: second op accepted in the done cycle
    @(posedge clk); #1;
    op = 3'd0; ra = 4'd1; rb = 4'd1; imm_en = 1; imm = 32'd1; start = 1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("b2b_first_done", done, 1);
    check("b2b_first_result", result, 32'd10);
    @(posedge clk); #1;
    start = 0;
    check("b2b_second_busy", busy, 1);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    check("b2b_second_latency", lat, 3);
    check("b2b_second_result", result, 32'd11);
    rd_check("b2b_r1", 4'd1, 32'd11);

    // clear dropped at TZ aborts the operation
    @(posedge clk); #1;
    op = 3'd0; ra = 4'd9; rb = 4'd1; imm_en = 1; imm = 32'd1; start = 1;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    clear = 0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    for (int i = 1; i < NR; i++) rd_check($sformatf("abort_r%0d", i), AW'(i), 0);
    @(posedge clk); #1;
    clear = 1;
    extra = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    check("abort_no_done", extra, 0);
    rd_check("abort_r9", 4'd9, 0);

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      @(posedge clk); #1;
      start   = ($urandom_range(0, 3) == 0);
      op      = 3'($urandom);
      ra      = AW'($urandom);
      rb      = AW'($urandom);
      rc      = AW'($urandom);
      imm_en  = 1'($urandom);
      imm     = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 40) : $urandom;
      ld_en   = ($urandom_range(0, 3) == 0);
      ld_addr = AW'($urandom);
      ld_data = $urandom;
      rd_addr = AW'($urandom);
    end
    @(posedge clk); #1;
    start = 0; ld_en = 0;
    repeat (6) @(posedge clk);
    #1;

    // 8-bit, 4-register instance
    s_ld_en = 1; s_ld_addr = 2'd1; s_ld_data = 8'hFF;
    @(posedge clk); #1;
    s_ld_en = 0;
    s_op = 3'd0; s_ra = 2'd2; s_rb = 2'd1; s_imm_en = 1; s_imm = 8'd1; s_start = 1;
    @(posedge clk); #1;
    s_start = 0;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (s_done) begin
        lat = k;
        break;
      end
    end
    check("small_latency", lat, 3);
    check("small_result", s_result, 8'h00);
    check("small_z", s_z, 1);
    check("small_c", s_c, 1);
    check("small_n", s_n, 0);
    s_rd_addr = 2'd1;
    #1;
    check("small_r1", s_rd_data, 8'hFF);
    @(posedge clk); #1;
    s_op = 3'd1; s_ra = 2'd3; s_rb = 2'd1; s_imm_en = 1; s_imm = 8'd1; s_start = 1;
    @(posedge clk); #1;
    s_start = 0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("small_sub_done", s_done, 1);
    check("small_sub_result", s_result, 8'hFE);
    check("small_sub_n", s_n, 1);
    check("small_sub_c", s_c, 0);
    s_rd_addr = 2'd3;
    #1;
    check("small_r3", s_rd_data, 8'hFE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
